// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Brief    : Shared state encoding, item prices and credit width.
//  Revision : 1.0  initial release
// ============================================================================
package vend_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [CREDIT_W-1:0] PRICE_A = 4'd3;
    localparam logic [CREDIT_W-1:0] PRICE_B = 4'd4;
    localparam logic [CREDIT_W-1:0] PRICE_C = 4'd5;
    localparam logic [CREDIT_W-1:0] PRICE_D = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Zero means "no valid selection": zero-hot and multi-hot both land here.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [3:0] sel);
        case (sel)
            4'b0001: price_of = PRICE_A;
            4'b0010: price_of = PRICE_B;
            4'b0100: price_of = PRICE_C;
            4'b1000: price_of = PRICE_D;
            default: price_of = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vend_change_unit
//  Brief    : Change down-counter and inter-pulse gap timer; drives nickel_out.
//  Revision : 1.0  initial release
// ============================================================================
module vend_change_unit #(
    parameter int CREDIT_W   = 4,
    parameter int CHANGE_GAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_active,
    input  logic                i_load,
    input  logic [CREDIT_W-1:0] i_load_value,
    output logic                o_nickel_out,
    output logic                o_last
);

    logic [CREDIT_W-1:0] r_count;
    logic [1:0]          r_gap;

    assign o_nickel_out = i_active && (r_count != '0) && (r_gap == 2'd0);
    assign o_last       = o_nickel_out && (r_count == CREDIT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_gap   <= 2'd0;
        end else if (i_load) begin
            r_count <= i_load_value;
            r_gap   <= 2'd0;
        end else if (o_nickel_out) begin
            r_count <= r_count - CREDIT_W'(1);
            r_gap   <= 2'(CHANGE_GAP);
        end else if (r_gap != 2'd0) begin
            r_gap   <= r_gap - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_sequencer
//  Brief    : Coin-credit vending sequencer with nickel change return.
//             Optional macro VEND_CANCEL_EN enables cancel/refund from CREDIT.
//  Revision : 1.0  initial release
// ============================================================================
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int CREDIT_MAX = 8,
    parameter int CHANGE_GAP = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a,
    input  logic                b,
    input  logic                c,
    input  logic                d,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                cancel,
    output logic                dispense,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_next;
    logic [CREDIT_W-1:0] r_price;
    logic [CREDIT_W-1:0] w_price_next;
    logic                r_coin_reject;

    logic [2:0]          w_coin_sum;
    logic [CREDIT_W:0]   w_credit_sum;
    logic                w_coin_any;
    logic                w_coin_open;
    logic                w_overflow;
    logic                w_coin_accept;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_buy;
    logic                w_cancel_take;
    logic                w_load;
    logic                w_change_last;

    assign w_coin_sum    = {1'b0, dime_in, nickel_in};
    assign w_coin_any    = nickel_in | dime_in;
    assign w_credit_sum  = {1'b0, r_credit} + {{(CREDIT_W-2){1'b0}}, w_coin_sum};
    assign w_overflow    = w_credit_sum > (CREDIT_W+1)'(CREDIT_MAX);
    assign w_coin_open   = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    assign w_coin_accept = w_coin_open && w_coin_any && !w_overflow;

    assign w_sel_price   = price_of({d, c, b, a});
    assign w_buy         = (r_state == ST_CREDIT) && (w_sel_price != '0) &&
                           (r_credit >= w_sel_price);

`ifdef VEND_CANCEL_EN
    assign w_cancel_take = (r_state == ST_CREDIT) && cancel && !w_buy;
`else
    logic w_cancel_unused;
    assign w_cancel_unused = cancel;
    assign w_cancel_take   = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        w_price_next  = r_price;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_accept) begin
                    w_credit_next = w_credit_sum[CREDIT_W-1:0];
                    w_state_next  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (w_coin_accept) begin
                    w_credit_next = w_credit_sum[CREDIT_W-1:0];
                end
                if (w_buy) begin
                    w_state_next = ST_VEND;
                    w_price_next = w_sel_price;
                end else if (w_cancel_take) begin
                    w_state_next = ST_CHANGE;
                    w_load       = 1'b1;
                end
            end
            ST_VEND: begin
                w_credit_next = r_credit - r_price;
                if (r_credit != r_price) begin
                    w_state_next = ST_CHANGE;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (nickel_out) begin
                    w_credit_next = r_credit - CREDIT_W'(1);
                end
                if (w_change_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_price       <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_credit      <= w_credit_next;
            r_price       <= w_price_next;
            r_coin_reject <= w_coin_any && !w_coin_accept;
        end
    end

    // The refund/remainder equals the credit the block will hold next cycle.
    vend_change_unit #(
        .CREDIT_W   (CREDIT_W),
        .CHANGE_GAP (CHANGE_GAP)
    ) u_change (
        .clk          (clock),
        .rst          (reset),
        .i_active     (r_state == ST_CHANGE),
        .i_load       (w_load),
        .i_load_value (w_credit_next),
        .o_nickel_out (nickel_out),
        .o_last       (w_change_last)
    );

    assign dispense    = (r_state == ST_VEND);
    assign busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_sequencer
//  Brief    : Directed bench with a timeline model of expected outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vend_sequencer;

    localparam int GAP   = 1;
    localparam int CMAX  = 8;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 0, b = 0, c = 0, d = 0;
    logic       nickel_in = 0, dime_in = 0, cancel = 0;
    logic       dispense, nickel_out, coin_reject, busy;
    logic [3:0] credit;

    vend_sequencer #(.CREDIT_MAX(CMAX), .CHANGE_GAP(GAP)) dut (
        .clock(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
        .nickel_in(nickel_in), .dime_in(dime_in), .cancel(cancel),
        .dispense(dispense), .nickel_out(nickel_out), .coin_reject(coin_reject),
        .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output timeline, indexed by cycle number.
    bit exp_disp [DEPTH];
    bit exp_nick [DEPTH];
    bit exp_rej  [DEPTH];
    bit exp_busy [DEPTH];
    int exp_cred [DEPTH];

    int n_checks = 0;
    int n_errors = 0;
    int m_credit = 0;
    int m_done   = 0;
    int n_nick = 0, n_disp = 0, last_nick = 0, prev_nick = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < DEPTH) begin
            check("dispense",    int'(dispense),    int'(exp_disp[cyc]));
            check("nickel_out",  int'(nickel_out),  int'(exp_nick[cyc]));
            check("coin_reject", int'(coin_reject), int'(exp_rej[cyc]));
            check("busy",        int'(busy),        int'(exp_busy[cyc]));
            check("credit",      int'(credit),      exp_cred[cyc]);
            check("disp_nick_exclusive", int'(dispense & nickel_out), 0);
        end
    end

    always @(negedge clk) begin
        if (nickel_out) begin
            prev_nick = last_nick;
            last_nick = cyc;
            n_nick++;
        end
        if (dispense) n_disp++;
    end

    function automatic int model_price(input logic [3:0] sel);
        case (sel)
            4'b0001: return 3;
            4'b0010: return 4;
            4'b0100: return 5;
            4'b1000: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic fill_credit(input int k, input int v);
        for (int j = k; j < DEPTH; j++) exp_cred[j] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n nickels starting in cycle start, GAP idle cycles between them.
    task automatic schedule_change(input int start, input int n);
        int p;
        for (int i = 0; i < n; i++) begin
            p = start + i * (GAP + 1);
            exp_nick[p] = 1'b1;
            fill_credit(p + 1, n - 1 - i);
            if (i < n - 1) begin
                for (int g = 0; g <= GAP; g++) exp_busy[p + g] = 1'b1;
            end else begin
                exp_busy[p] = 1'b1;
            end
        end
        m_done   = (n == 0) ? start : start + (n - 1) * (GAP + 1) + 1;
        m_credit = 0;
    endtask

    // One input cycle while the machine is accepting coins / selections.
    task automatic step(input logic [3:0] sel, input logic n, input logic dm, input logic cx);
        int  k, sum, price, newc;
        bit  buy, canc;
        k = cyc;
        {d, c, b, a} = sel;
        nickel_in = n; dime_in = dm; cancel = cx;
        sum   = int'(n) + 2 * int'(dm);
        price = model_price(sel);
        buy   = (price != 0) && (m_credit > 0) && (m_credit >= price);
`ifdef VEND_CANCEL_EN
        canc  = cx && (m_credit > 0) && !buy;
`else
        canc  = 1'b0;
`endif
        newc = m_credit;
        if (sum > 0) begin
            if (m_credit + sum > CMAX) exp_rej[k + 1] = 1'b1;
            else newc = m_credit + sum;
        end
        if (newc != m_credit) fill_credit(k + 1, newc);
        if (buy) begin
            exp_disp[k + 1] = 1'b1;
            exp_busy[k + 1] = 1'b1;
            fill_credit(k + 2, newc - price);
            schedule_change(k + 2, newc - price);
        end else if (canc) begin
            schedule_change(k + 1, newc);
        end else begin
            m_credit = newc;
            m_done   = k + 1;
        end
        tick();
        {d, c, b, a} = 4'b0000;
        nickel_in = 0; dime_in = 0; cancel = 0;
    endtask

    // Coin offered while vending or returning change.
    task automatic busy_coin(input logic n, input logic dm);
        nickel_in = n; dime_in = dm;
        if (n | dm) exp_rej[cyc + 1] = 1'b1;
        tick();
        nickel_in = 0; dime_in = 0;
    endtask

    task automatic wait_done();
        while (cyc < m_done) tick();
    endtask

    task automatic do_reset();
        int k;
        k = cyc;
        for (int j = k; j < DEPTH; j++) begin
            exp_disp[j] = 0; exp_nick[j] = 0; exp_rej[j] = 0; exp_busy[j] = 0; exp_cred[j] = 0;
        end
        m_credit = 0;
        m_done   = k;
        #1 reset = 1'b1;
        #1;
        check("rst_dispense",    int'(dispense),    0);
        check("rst_nickel_out",  int'(nickel_out),  0);
        check("rst_coin_reject", int'(coin_reject), 0);
        check("rst_busy",        int'(busy),        0);
        check("rst_credit",      int'(credit),      0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    int d0, n0, exp_refund;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("reset_credit", int'(credit), 0);
        check("reset_busy",   int'(busy),   0);

        // Three nickels then a: exact payment.
        d0 = n_disp; n0 = n_nick;
        repeat (3) step(4'b0000, 1, 0, 0);
        wait_done();
        check("three_nickels_credit", int'(credit), 3);
        step(4'b0001, 0, 0, 0);
        wait_done();
        tick();
        check("exact_disp_count", n_disp - d0, 1);
        check("exact_nick_count", n_nick - n0, 0);
        check("exact_credit",     int'(credit), 0);

        // Two dimes then a: one nickel back; coin during VEND is rejected.
        d0 = n_disp; n0 = n_nick;
        repeat (2) step(4'b0000, 0, 1, 0);
        step(4'b0001, 0, 0, 0);
        busy_coin(1, 0);
        wait_done();
        tick();
        check("change1_disp_count", n_disp - d0, 1);
        check("change1_nick_count", n_nick - n0, 1);
        check("change1_credit",     int'(credit), 0);

        // Four dimes to the cap, fifth rejected, then d: two nickels.
        n0 = n_nick;
        repeat (4) step(4'b0000, 0, 1, 0);
        wait_done();
        check("cap_credit", int'(credit), 8);
        step(4'b0000, 0, 1, 0);
        check("cap_reject", int'(coin_reject), 1);
        wait_done();
        check("cap_credit_held", int'(credit), 8);
        step(4'b1000, 0, 0, 0);
        wait_done();
        tick();
        check("cap_nick_count",   n_nick - n0, 2);
        check("cap_nick_spacing", last_nick - prev_nick, 2);

        // Credit 5, multi-hot ignored, insufficient d ignored, then c.
        d0 = n_disp; n0 = n_nick;
        step(4'b0000, 1, 1, 0);
        step(4'b0000, 0, 1, 0);
        step(4'b0110, 0, 0, 0);
        step(4'b1000, 0, 0, 0);
        tick();
        check("multihot_no_disp", n_disp - d0, 0);
        check("multihot_credit",  int'(credit), 5);
        step(4'b0100, 0, 0, 0);
        wait_done();
        tick();
        check("c_disp_count", n_disp - d0, 1);
        check("c_nick_count", n_nick - n0, 0);

        // Coin in the same cycle as a qualifying selection is still added.
        step(4'b0000, 1, 1, 0);
        step(4'b0001, 1, 0, 0);
        busy_coin(0, 1);
        wait_done();

        // Cancel together with a qualifying purchase: purchase wins.
        step(4'b0000, 0, 1, 0);
        step(4'b0000, 0, 1, 0);
        step(4'b0001, 0, 0, 1);
        wait_done();

        // Cancel alone with credit 3.
`ifdef VEND_CANCEL_EN
        exp_refund = 3;
`else
        exp_refund = 0;
`endif
        d0 = n_disp; n0 = n_nick;
        step(4'b0000, 1, 1, 0);
        step(4'b0000, 0, 0, 1);
        wait_done();
        repeat (8) tick();
        check("cancel_nick_count", n_nick - n0, exp_refund);
        check("cancel_disp_count", n_disp - d0, 0);
        step(4'b0001, 0, 0, 0);
        wait_done();

        // Both coins at once overflow; single dime to the cap accepted.
        repeat (3) step(4'b0000, 0, 1, 0);
        step(4'b0000, 1, 1, 0);
        step(4'b0000, 0, 1, 0);
        wait_done();
        check("both_overflow_credit", int'(credit), 8);
        step(4'b0010, 0, 0, 0);
        wait_done();

        // Remainder 3, reset after the first nickel.
        n0 = n_nick;
        repeat (3) step(4'b0000, 0, 1, 0);
        step(4'b0001, 0, 0, 0);
        tick();
        tick();
        do_reset();
        repeat (10) tick();
        check("reset_change_nick_count", n_nick - n0, 1);
        check("reset_change_credit", int'(credit), 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter CREDIT_MAX, default 8: maximum held credit in nickel units; legal range 6..15.
REQ-002 Parameter CHANGE_GAP, default 1: low cycles between consecutive nickel_out pulses; legal range 0..3.
REQ-003 clock  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 a, b, c, d  input  1 each  item select levels; a selection is valid only when exactly one is high.
REQ-006 nickel_in  input  1  one-cycle pulse per 5c coin.
REQ-007 dime_in  input  1  one-cycle pulse per 10c coin.
REQ-008 cancel  input  1  one-cycle refund request; used only under VEND_CANCEL_EN.
REQ-009 dispense  output  1  one-cycle vend pulse.
REQ-010 nickel_out  output  1  one-cycle pulse per 5c returned.
REQ-011 coin_reject  output  1  one-cycle pulse per rejected coin cycle.
REQ-012 busy  output  1  high in VEND and CHANGE.
REQ-013 credit  output  4  current credit in nickel units.

Function
REQ-014 The block SHALL implement states IDLE, CREDIT, VEND and CHANGE, encoded as registered state.
REQ-015 Prices SHALL be: a=3, b=4, c=5, d=6 nickel units.
REQ-016 In IDLE and CREDIT, coins SHALL add to credit (nickel +1, dime +2, both in the same cycle +3), visible on credit in the next cycle.
REQ-017 If a cycle's coin sum would exceed CREDIT_MAX, all coins of that cycle SHALL be rejected: coin_reject pulses in the next cycle, and credit is unchanged.
REQ-018 IDLE SHALL move to CREDIT when credit becomes nonzero.
REQ-019 In CREDIT, select lines SHALL be sampled every cycle; zero-hot and multi-hot patterns SHALL be ignored, and the selection MAY change freely before purchase.
REQ-020 CREDIT SHALL move to VEND in the cycle after a valid selection is sampled with registered credit >= price; coins accepted in that same sampling cycle SHALL still be added.
REQ-021 VEND SHALL last exactly one cycle with dispense high, and SHALL load remainder = credit - price.
REQ-022 VEND SHALL move to CHANGE if remainder > 0, else to IDLE with credit 0.
REQ-023 In CHANGE, the first nickel_out pulse SHALL occur in the cycle after VEND; each pulse decrements credit by 1; pulses are separated by CHANGE_GAP low cycles.
REQ-024 CHANGE SHALL move to IDLE in the cycle after the last pulse.
REQ-025 Coins arriving in VEND or CHANGE SHALL be rejected (coin_reject in the next cycle) and never added to credit.
REQ-026 dispense and nickel_out SHALL never be high in the same cycle.

Reset
REQ-027 On reset assertion, state SHALL become IDLE, credit 0, and dispense, nickel_out, coin_reject and busy 0 immediately, without waiting for a clock edge.
REQ-028 A reset during CHANGE SHALL discard the outstanding change: no further nickel_out pulses after reset deasserts.

Configuration
REQ-029 With VEND_CANCEL_EN defined, a cancel pulse in CREDIT SHALL move the block to CHANGE and refund the full credit with no dispense; if cancel coincides with a qualifying purchase, the purchase SHALL win.
REQ-030 Without VEND_CANCEL_EN, the cancel port SHALL remain present and be ignored.

Structure
REQ-031 Package vend_pkg SHALL hold the state enum, the PRICE_A..PRICE_D constants and the credit width constant.
REQ-032 Sub-module vend_change_unit SHALL hold the change down-counter and gap timer, and SHALL drive nickel_out.

Verification
REQ-033 Three nickels, then select a -> one dispense pulse, no nickel_out, credit 0, back to IDLE.
REQ-034 Two dimes, then select a -> dispense, then exactly one nickel_out, credit 0.
REQ-035 Four dimes (credit 8), fifth dime -> coin_reject, credit stays 8; select d -> dispense, then two nickel_out pulses 2 cycles apart.
REQ-036 Credit 5 with b and c high together -> no dispense; then c alone -> dispense, no change.
REQ-037 VEND_CANCEL_EN defined, credit 3, cancel -> three nickel_out pulses, no dispense; same stimulus with the macro undefined -> no response.
REQ-038 Remainder 3, reset asserted after the first nickel_out -> all outputs 0 immediately, no further pulses, credit 0.
